// File: rtl/iram_arb_pkg.sv
// iram_arb_pkg: FSM states, line geometry and lane strobes shared by the SRAM port arbiter
package iram_arb_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_TAIL = 3'd4;
   localparam int LINE_BYTES = 16;
   localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h01ff_fff0;
   localparam logic [15:0] LANE0_STRB = 16'h000f;
   localparam logic [15:0] LANE1_STRB = 16'h00f0;
   localparam logic [15:0] LANE2_STRB = 16'h0f00;
   localparam logic [15:0] LANE3_STRB = 16'hf000;
   function automatic logic [7:0] console_byte(input logic [127:0] d, input logic [15:0] s);
      return |(s & LANE0_STRB) ? d[7:0] : |(s & LANE1_STRB) ? d[39:32] :
             |(s & LANE2_STRB) ? d[71:64] : |(s & LANE3_STRB) ? d[103:96] : 8'h00;
   endfunction
endpackage

// File: rtl/iram_burst_ctr.sv
// iram_burst_ctr: latched burst base/length, beat counter and wrapping line address
module iram_burst_ctr #(
   parameter int LINE_AW = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [LINE_AW-1:0] base_in,
   input  logic [3:0]         len_in,
   input  logic               adv,
   output logic [LINE_AW-1:0] line,
   output logic               last
);
   logic [LINE_AW-1:0] base;
   logic [3:0] len, beat;
   always_ff @(posedge clk)
      if (rst) begin
         base <= '0;
         len  <= '0;
         beat <= '0;
      end else if (load) begin
         base <= base_in;
         len  <= len_in;
         beat <= '0;
      end else if (adv) begin
         beat <= beat + 4'd1;
      end
   // natural truncation wraps a burst past the top line back to line 0
   assign line = base + LINE_AW'(beat);
   assign last = beat == len;
endmodule

// File: rtl/iram_port_arb.sv
// iram_port_arb: CPU burst / program-loader arbiter for the 128-bit SRAM; console tap under IRAM_PORT_ARB_CONSOLE_EN
module iram_port_arb
   import iram_arb_pkg::*;
#(
   parameter int          LINE_AW      = 24,
   parameter int          MAX_LD_RUN   = 8,
   parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cpu_req,
   input  logic               cpu_we,
   input  logic [31:0]        cpu_addr,
   input  logic [3:0]         cpu_len,
   output logic               cpu_gnt,
   input  logic               cpu_wvalid,
   input  logic [127:0]       cpu_wdata,
   input  logic [15:0]        cpu_wstrb,
   output logic               cpu_wready,
   output logic               cpu_rvalid,
   output logic [127:0]       cpu_rdata,
   output logic               cpu_rlast,
   input  logic               ld_wen,
   input  logic [31:0]        ld_addr,
   input  logic [31:0]        ld_wdata,
   output logic               ld_ready,
   output logic               mem_cen,
   output logic               mem_wen,
   output logic [LINE_AW-1:0] mem_addr,
   output logic [127:0]       mem_wdata,
   output logic [15:0]        mem_wstrb,
   input  logic [127:0]       mem_rdata,
   output logic               console_valid,
   output logic [7:0]         console_char
);
   localparam int RW  = $clog2(MAX_LD_RUN + 1);
   localparam int LSB = $clog2(LINE_BYTES);
   logic [2:0] state, state_nx;
   logic [RW-1:0] ld_run;
   logic idle, ld_win, acc, wr, last, con;
   logic [LINE_AW-1:0] line;
   logic unused;
   assign unused = ^{cpu_addr[LSB-1:0], cpu_addr[31:LINE_AW+LSB], ld_addr[31:LINE_AW+2], CONSOLE_ADDR};
   assign idle = state == ST_IDLE && !rst;
   // the loader normally wins; a CPU starved for MAX_LD_RUN loader grants takes the next slot
   assign cpu_gnt = idle && cpu_req && (!ld_wen || ld_run == RW'(MAX_LD_RUN));
   assign ld_win = idle && ld_wen && !cpu_gnt;
   assign ld_ready = state == ST_LOAD;
   assign acc = state == ST_WR && cpu_wvalid;
   assign cpu_wready = acc;
   assign wr = acc && !con;
   assign mem_cen = ld_ready || state == ST_RD || wr;
   assign mem_wen = ld_ready || wr;
   assign mem_addr = ld_ready ? ld_addr[LINE_AW+1:2] : mem_cen ? line : '0;
   assign mem_wdata = ld_ready ? {4{ld_wdata}} : wr ? cpu_wdata : '0;
   assign mem_wstrb = ld_ready ? LANE0_STRB << {ld_addr[1:0], 2'b00} : wr ? cpu_wstrb : '0;
   assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
   always_comb
      state_nx = state == ST_IDLE ? (cpu_gnt ? (cpu_we ? ST_WR : ST_RD) : ld_win ? ST_LOAD : ST_IDLE) :
                 state == ST_RD   ? (last ? ST_TAIL : ST_RD) :
                 state == ST_WR   ? (acc && last ? ST_IDLE : ST_WR) : ST_IDLE;
   always_ff @(posedge clk)
      if (rst) begin
         state      <= ST_IDLE;
         ld_run     <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rlast  <= 1'b0;
      end else begin
         state      <= state_nx;
         ld_run     <= cpu_gnt || !cpu_req ? '0 : ld_win ? ld_run + 1'b1 : ld_run;
         cpu_rvalid <= state == ST_RD;
         cpu_rlast  <= state == ST_RD && last;
      end
   iram_burst_ctr #(.LINE_AW(LINE_AW)) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .load    (cpu_gnt),
      .base_in (cpu_addr[LINE_AW+LSB-1:LSB]),
      .len_in  (cpu_len),
      .adv     (state == ST_RD || acc),
      .line    (line),
      .last    (last)
   );
`ifdef IRAM_PORT_ARB_CONSOLE_EN
   always_ff @(posedge clk)
      if (rst) con <= 1'b0;
      else if (cpu_gnt) con <= cpu_we && cpu_len == 4'd0 && cpu_addr == CONSOLE_ADDR;
   assign console_valid = acc && con;
   assign console_char = console_valid ? console_byte(cpu_wdata, cpu_wstrb) : 8'h00;
`else
   assign con = 1'b0;
   assign console_valid = 1'b0;
   assign console_char = 8'h00;
`endif
endmodule
